// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle LEGv8 control unit that walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB and parks in HALT on an
// illegal opcode until reset.
// Ports: c (clock), r (async active-low reset), instr (instruction word),
//   status {N,Z,C,V}, mem_ready (memory handshake);
//   rd_addr/rn_addr/rm_addr, imm, alu_op, alu_b_sel (decoded fields,
//   registered in DECODE); reg_we, mem_rd, mem_wr, ir_load, pc_load
//   (strobes); pc_sel; state; illegal.
// Optional: define CU_FLAG_BRANCH_EN to decode B.cond.
module control_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_AW     = 5
) (
   input  logic                  c,
   input  logic                  r,
   input  logic [31:0]           instr,
   input  logic [3:0]            status,
   input  logic                  mem_ready,
   output logic [REG_AW-1:0]     rd_addr,
   output logic [REG_AW-1:0]     rn_addr,
   output logic [REG_AW-1:0]     rm_addr,
   output logic [DATA_WIDTH-1:0] imm,
   output logic [2:0]            alu_op,
   output logic                  alu_b_sel,
   output logic                  reg_we,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic                  ir_load,
   output logic                  pc_load,
   output logic                  pc_sel,
   output logic [2:0]            state,
   output logic                  illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      C_ALU, C_LD, C_ST, C_CBZ, C_CBNZ, C_B, C_BC, C_ILL
   } cls_e;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_ORR  = 3'd3;
   localparam logic [2:0] OP_PASS = 3'd4;

   state_e                state_q, state_d;
   logic                  run_q;
   cls_e                  cls_q, cls_d;
   logic [REG_AW-1:0]     rd_q, rn_q, rm_q, rm_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d, mov_base;
   logic [2:0]            alu_q, alu_d;
   logic                  bsel_q, bsel_d;
   logic                  taken;

`ifdef CU_FLAG_BRANCH_EN
   logic [3:0]            cond_q;

   // Odd condition codes invert the even one below them; AL is 4'hE.
   function automatic logic cond_ok(input logic [3:0] cd,
                                    input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (cd[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return cd[0] ? ~base : base;
   endfunction
`else
   logic                  unused_status;
   assign unused_status = ^{status[3], status[1:0]};
`endif

   // Instruction decode, sampled into the field registers in DECODE
   always_comb begin
      cls_d    = C_ILL;
      alu_d    = OP_ADD;
      bsel_d   = 1'b0;
      imm_d    = '0;
      rm_d     = REG_AW'(instr[20:16]);
      mov_base = DATA_WIDTH'(instr[20:5]);
      unique case (1'b1)
         instr[31:21] == 11'b10001011000: begin
            cls_d = C_ALU;
         end
         instr[31:21] == 11'b11001011000: begin
            cls_d = C_ALU;
            alu_d = OP_SUB;
         end
         instr[31:21] == 11'b10001010000: begin
            cls_d = C_ALU;
            alu_d = OP_AND;
         end
         instr[31:21] == 11'b10101010000: begin
            cls_d = C_ALU;
            alu_d = OP_ORR;
         end
         instr[31:22] == 10'b1001000100: begin
            cls_d  = C_ALU;
            bsel_d = 1'b1;
            imm_d  = DATA_WIDTH'(instr[21:10]);
         end
         instr[31:22] == 10'b1101000100: begin
            cls_d  = C_ALU;
            alu_d  = OP_SUB;
            bsel_d = 1'b1;
            imm_d  = DATA_WIDTH'(instr[21:10]);
         end
         instr[31:23] == 9'b110100101: begin
            // hw of 2 or 3 shifts past a 32-bit datapath
            if (DATA_WIDTH == 64 || !instr[22]) begin
               cls_d  = C_ALU;
               alu_d  = OP_PASS;
               bsel_d = 1'b1;
               imm_d  = mov_base << {instr[22:21], 4'b0000};
            end
         end
         instr[31:24] == 8'b10110100: begin
            cls_d = C_CBZ;
            alu_d = OP_PASS;
            rm_d  = REG_AW'(instr[4:0]);
            imm_d = {{(DATA_WIDTH-21){instr[23]}}, instr[23:5], 2'b00};
         end
         instr[31:24] == 8'b10110101: begin
            cls_d = C_CBNZ;
            alu_d = OP_PASS;
            rm_d  = REG_AW'(instr[4:0]);
            imm_d = {{(DATA_WIDTH-21){instr[23]}}, instr[23:5], 2'b00};
         end
         instr[31:26] == 6'b000101: begin
            cls_d  = C_B;
            alu_d  = OP_PASS;
            bsel_d = 1'b1;
            imm_d  = {{(DATA_WIDTH-28){instr[25]}}, instr[25:0], 2'b00};
         end
         instr[31:21] == 11'b11111000010: begin
            cls_d  = C_LD;
            bsel_d = 1'b1;
            imm_d  = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
         end
         instr[31:21] == 11'b11111000000: begin
            cls_d  = C_ST;
            bsel_d = 1'b1;
            rm_d   = REG_AW'(instr[4:0]);
            imm_d  = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
         end
`ifdef CU_FLAG_BRANCH_EN
         instr[31:24] == 8'b01010100: begin
            if (instr[3:0] != 4'hF) begin
               cls_d  = C_BC;
               alu_d  = OP_PASS;
               bsel_d = 1'b1;
               imm_d  = {{(DATA_WIDTH-21){instr[23]}}, instr[23:5], 2'b00};
            end
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      unique case (cls_q)
         C_CBZ:   taken = status[2];
         C_CBNZ:  taken = ~status[2];
         C_B:     taken = 1'b1;
`ifdef CU_FLAG_BRANCH_EN
         C_BC:    taken = cond_ok(cond_q, status);
`endif
         default: taken = 1'b0;
      endcase
   end

   // run_q keeps the first cycle after reset release idle
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         cls_q  <= C_ILL;
         rd_q   <= '0;
         rn_q   <= '0;
         rm_q   <= '0;
         imm_q  <= '0;
         alu_q  <= OP_ADD;
         bsel_q <= 1'b0;
`ifdef CU_FLAG_BRANCH_EN
         cond_q <= '0;
`endif
      end else if (state_q == S_DECODE) begin
         cls_q  <= cls_d;
         rd_q   <= REG_AW'(instr[4:0]);
         rn_q   <= REG_AW'(instr[9:5]);
         rm_q   <= rm_d;
         imm_q  <= imm_d;
         alu_q  <= alu_d;
         bsel_q <= bsel_d;
`ifdef CU_FLAG_BRANCH_EN
         cond_q <= instr[3:0];
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  if (run_q && mem_ready) state_d = S_DECODE;
         S_DECODE: state_d = (cls_d == C_ILL) ? S_HALT : S_EXEC;
         S_EXEC: begin
            unique case (cls_q)
               C_ALU:      state_d = S_WB;
               C_LD, C_ST: state_d = S_MEM;
               default:    state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ready) state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ir_load = 1'b0;
      pc_load = 1'b0;
      pc_sel  = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_rd  = run_q;
            ir_load = run_q & mem_ready;
            pc_load = run_q & mem_ready;
         end
         S_EXEC: begin
            pc_load = taken;
            pc_sel  = taken;
         end
         S_MEM: begin
            mem_rd = (cls_q == C_LD);
            mem_wr = (cls_q == C_ST);
         end
         S_WB:    reg_we  = 1'b1;
         S_HALT:  illegal = 1'b1;
         default: ;
      endcase
   end

   assign state     = state_q;
   assign rd_addr   = rd_q;
   assign rn_addr   = rn_q;
   assign rm_addr   = rm_q;
   assign imm       = imm_q;
   assign alu_op    = alu_q;
   assign alu_b_sel = bsel_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed bench for control_sequencer
// with a per-instruction phase model checked every cycle.
module tb_control_sequencer;

   localparam int DW = 64;

   localparam int K_ADD  = 0;
   localparam int K_SUB  = 1;
   localparam int K_AND  = 2;
   localparam int K_ORR  = 3;
   localparam int K_ADDI = 4;
   localparam int K_SUBI = 5;
   localparam int K_MOVZ = 6;
   localparam int K_CBZ  = 7;
   localparam int K_CBNZ = 8;
   localparam int K_B    = 9;
   localparam int K_LDUR = 10;
   localparam int K_STUR = 11;

   logic          c = 1'b0;
   logic          r = 1'b1;
   logic [31:0]   instr = '0;
   logic [3:0]    status = '0;
   logic          mem_ready = 1'b0;
   logic [4:0]    rd_addr, rn_addr, rm_addr;
   logic [DW-1:0] imm;
   logic [2:0]    alu_op;
   logic          alu_b_sel, reg_we, mem_rd, mem_wr;
   logic          ir_load, pc_load, pc_sel, illegal;
   logic [2:0]    state;

   control_sequencer #(.DATA_WIDTH(DW), .REG_AW(5)) dut (
      .c(c), .r(r), .instr(instr), .status(status),
      .mem_ready(mem_ready),
      .rd_addr(rd_addr), .rn_addr(rn_addr), .rm_addr(rm_addr),
      .imm(imm), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
      .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
      .state(state), .illegal(illegal)
   );

   always #5 c = ~c;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic [2:0]  e_state = '0;
   logic [5:0]  e_strb = '0;
   logic        e_ill = 1'b0;
   logic [4:0]  m_rd = '0, m_rn = '0, m_rm = '0;
   logic [63:0] m_imm = '0;
   logic [2:0]  m_alu = '0;
   logic        m_bsel = 1'b0;
   bit          k_rdrn = 1'b1, k_rm = 1'b1, k_imm = 1'b1;
   bit          k_alu = 1'b1, k_bsel = 1'b1;
   int          cyc_idx = 0;

   int tot_we = 0, tot_br = 0, tot_mrd = 0, tot_ir = 0;
   int last_we_cyc = 0;

   always @(negedge c) begin
      if (chk_en) begin
         chk("state", 64'(state), 64'(e_state));
         chk("strobes",
             64'({mem_rd, mem_wr, ir_load, pc_load, pc_sel, reg_we}),
             64'(e_strb));
         chk("illegal", 64'(illegal), 64'(e_ill));
         if (k_rdrn) begin
            chk("rd_addr", 64'(rd_addr), 64'(m_rd));
            chk("rn_addr", 64'(rn_addr), 64'(m_rn));
         end
         if (k_rm)   chk("rm_addr", 64'(rm_addr), 64'(m_rm));
         if (k_imm)  chk("imm", imm, m_imm);
         if (k_alu)  chk("alu_op", 64'(alu_op), 64'(m_alu));
         if (k_bsel) chk("alu_b_sel", 64'(alu_b_sel), 64'(m_bsel));
      end
      if (reg_we) begin
         tot_we++;
         last_we_cyc = cyc_idx;
      end
      if (pc_load && pc_sel) tot_br++;
      if (mem_rd && state == 3'd3) tot_mrd++;
      if (ir_load) tot_ir++;
   end

   task automatic next();
      @(posedge c);
      #1;
   endtask

   task automatic expect_ph(input logic [2:0] s, input logic rd_,
                            input logic wr_, input logic ir_,
                            input logic pl_, input logic ps_,
                            input logic we_, input logic il_);
      e_state = s;
      e_strb  = {rd_, wr_, ir_, pl_, ps_, we_};
      e_ill   = il_;
   endtask

   task automatic do_reset();
      r = 1'b0;
      chk_en = 1'b1;
      expect_ph(3'd0, 0, 0, 0, 0, 0, 0, 0);
      m_rd = '0; m_rn = '0; m_rm = '0; m_imm = '0;
      m_alu = '0; m_bsel = 1'b0;
      k_rdrn = 1; k_rm = 1; k_imm = 1; k_alu = 1; k_bsel = 1;
      #1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_strobes",
          64'({mem_rd, mem_wr, ir_load, pc_load, pc_sel, reg_we}), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_fields",
          64'({rd_addr, rn_addr, rm_addr, alu_op, alu_b_sel}), 64'd0);
      chk("rst_imm", imm, 64'd0);
      next();
      r = 1'b1;
      next();
   endtask

   function automatic logic [31:0] enc(input int k, input int rd,
                                       input int rn, input int rm,
                                       input logic [63:0] f,
                                       input int hw);
      logic [4:0] d, n, m;
      d = rd[4:0];
      n = rn[4:0];
      m = rm[4:0];
      case (k)
         K_ADD:  return {11'b10001011000, m, 6'd0, n, d};
         K_SUB:  return {11'b11001011000, m, 6'd0, n, d};
         K_AND:  return {11'b10001010000, m, 6'd0, n, d};
         K_ORR:  return {11'b10101010000, m, 6'd0, n, d};
         K_ADDI: return {10'b1001000100, f[11:0], n, d};
         K_SUBI: return {10'b1101000100, f[11:0], n, d};
         K_MOVZ: return {9'b110100101, hw[1:0], f[15:0], d};
         K_CBZ:  return {8'b10110100, f[18:0], d};
         K_CBNZ: return {8'b10110101, f[18:0], d};
         K_B:    return {6'b000101, f[25:0]};
         K_LDUR: return {11'b11111000010, f[8:0], 2'b00, n, d};
         default: return {11'b11111000000, f[8:0], 2'b00, n, d};
      endcase
   endfunction

   function automatic longint sx(input logic [63:0] v, input int b);
      longint x;
      x = longint'(v);
      if (v[b-1]) x = x - (longint'(1) << b);
      return x;
   endfunction

   function automatic logic [63:0] imm_of(input int k,
                                          input logic [63:0] f,
                                          input int hw);
      case (k)
         K_ADDI, K_SUBI: return f & 64'hFFF;
         K_LDUR, K_STUR: return 64'(sx(f & 64'h1FF, 9));
         K_CBZ, K_CBNZ:  return 64'(sx(f & 64'h7FFFF, 19) * 4);
         K_B:            return 64'(sx(f & 64'h3FFFFFF, 26) * 4);
         K_MOVZ:         return (f & 64'hFFFF) * (64'd1 << (16 * hw));
         default:        return 64'd0;
      endcase
   endfunction

   function automatic logic [2:0] alu_of(input int k);
      case (k)
         K_SUB, K_SUBI: return 3'd1;
         K_AND:         return 3'd2;
         K_ORR:         return 3'd3;
         K_MOVZ, K_CBZ, K_CBNZ, K_B: return 3'd4;
         default:       return 3'd0;
      endcase
   endfunction

   task automatic run_instr(input int k, input int rd, input int rn,
                            input int rm, input logic [63:0] f,
                            input int hw, input int fst, input int mst,
                            input logic [3:0] st, input bit abort_mem);
      logic [31:0] w;
      bit is_r, is_cb, is_mem, tk;
      w      = enc(k, rd, rn, rm, f, hw);
      is_r   = (k <= K_ORR);
      is_cb  = (k == K_CBZ) || (k == K_CBNZ);
      is_mem = (k == K_LDUR) || (k == K_STUR);
      cyc_idx = 0;
      instr = w;
      for (int i = 0; i <= fst; i++) begin
         cyc_idx++;
         mem_ready = (i == fst);
         status = 4'($urandom);
         expect_ph(3'd0, 1, 0, mem_ready, mem_ready, 0, 0, 0);
         next();
      end
      cyc_idx++;
      mem_ready = 1'($urandom);
      status = 4'($urandom);
      expect_ph(3'd1, 0, 0, 0, 0, 0, 0, 0);
      next();
      m_rd   = 5'(w % 32);
      m_rn   = 5'((w / 32) % 32);
      m_rm   = is_r ? 5'(rm) : 5'(w % 32);
      m_imm  = imm_of(k, f, hw);
      m_alu  = alu_of(k);
      m_bsel = (k == K_ADDI) || (k == K_SUBI) || (k == K_MOVZ);
      k_rm   = is_r || is_cb || (k == K_STUR);
      k_imm  = !is_r;
      k_alu  = !(is_mem || k == K_B);
      k_bsel = k_alu;
      cyc_idx++;
      status = st;
      mem_ready = 1'($urandom);
      tk = (k == K_B) || (k == K_CBZ && st[2]) || (k == K_CBNZ && !st[2]);
      expect_ph(3'd2, 0, 0, 0, tk, tk, 0, 0);
      next();
      if (is_mem) begin
         for (int i = 0; i <= mst; i++) begin
            cyc_idx++;
            mem_ready = (i == mst);
            status = 4'($urandom);
            expect_ph(3'd3, k == K_LDUR, k == K_STUR, 0, 0, 0, 0, 0);
            if (abort_mem) begin
               #1;
               chk("mem_wr_before_rst", 64'(mem_wr), 64'(k == K_STUR));
               do_reset();
               return;
            end
            next();
         end
      end
      if (k <= K_MOVZ || k == K_LDUR) begin
         cyc_idx++;
         mem_ready = 1'($urandom);
         expect_ph(3'd4, 0, 0, 0, 0, 0, 1, 0);
         next();
      end
   endtask

   task automatic run_illegal(input logic [31:0] w, input int hold);
      int ir0;
      instr = w;
      mem_ready = 1'b1;
      expect_ph(3'd0, 1, 0, 1, 1, 0, 0, 0);
      next();
      expect_ph(3'd1, 0, 0, 0, 0, 0, 0, 0);
      next();
      k_rdrn = 0; k_rm = 0; k_imm = 0; k_alu = 0; k_bsel = 0;
      ir0 = tot_ir;
      for (int i = 0; i < hold; i++) begin
         mem_ready = 1'($urandom);
         status = 4'($urandom);
         expect_ph(3'd5, 0, 0, 0, 0, 0, 0, 1);
         next();
      end
      chk("halt_state", 64'(state), 64'd5);
      chk("halt_illegal", 64'(illegal), 64'd1);
      chk("halt_no_irload", 64'(tot_ir - ir0), 64'd0);
      do_reset();
   endtask

   initial begin
      int we0, br0, mrd0, k;
      #3;
      do_reset();

      we0 = tot_we;
      run_instr(K_ADDI, 4, 31, 0, 64'd100, 0, 0, 0, 4'd0, 0);
      chk("addi_imm", imm, 64'd100);
      chk("addi_rd", 64'(rd_addr), 64'd4);
      chk("addi_rn", 64'(rn_addr), 64'd31);
      chk("addi_alu", 64'(alu_op), 64'd0);
      chk("addi_bsel", 64'(alu_b_sel), 64'd1);
      chk("addi_we_cycle", 64'(last_we_cyc), 64'd4);
      chk("addi_we_count", 64'(tot_we - we0), 64'd1);

      run_instr(K_MOVZ, 9, 0, 0, 64'd1200, 0, 0, 0, 4'd0, 0);
      chk("movz0_imm", imm, 64'd1200);
      chk("movz0_alu", 64'(alu_op), 64'd4);
      run_instr(K_MOVZ, 9, 0, 0, 64'd1, 1, 0, 0, 4'd0, 0);
      chk("movz1_imm", imm, 64'd65536);

      br0 = tot_br;
      run_instr(K_CBZ, 4, 0, 0, 64'd6, 0, 0, 0, 4'b0100, 0);
      chk("cbz_taken", 64'(tot_br - br0), 64'd1);
      chk("cbz_imm", imm, 64'd24);
      br0 = tot_br;
      run_instr(K_CBZ, 4, 0, 0, 64'd6, 0, 0, 0, 4'b0000, 0);
      chk("cbz_not_taken", 64'(tot_br - br0), 64'd0);

      mrd0 = tot_mrd;
      we0 = tot_we;
      run_instr(K_LDUR, 10, 8, 0, 64'd0, 0, 0, 3, 4'd0, 0);
      chk("ldur_mem_rd_cycles", 64'(tot_mrd - mrd0), 64'd4);
      chk("ldur_we_count", 64'(tot_we - we0), 64'd1);

      run_instr(K_STUR, 3, 8, 0, 64'd0, 0, 0, 2, 4'd0, 1);

      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 11);
         run_instr(k, $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 3), 4'($urandom), 0);
      end

      run_illegal(32'hFFFF_FFFF, 6);
`ifndef CU_FLAG_BRANCH_EN
      run_illegal({8'b01010100, 19'd5, 1'b0, 4'd0}, 3);
`endif
      run_instr(K_ADD, 1, 2, 3, 64'd0, 0, 1, 0, 4'd0, 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
